// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - request sequencer between the CPU port, direct-mapped cache and backing memory
module cache_miss_ctrl #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req_valid,
   output logic                  cpu_req_ready,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic                  cpu_wr_en,
   output logic                  cpu_resp_valid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_err,
   output logic [ADDR_WIDTH-1:0] cache_addr,
   output logic [DATA_WIDTH-1:0] cache_data_in,
   output logic                  cache_wr_en,
   input  logic                  cache_hit,
   input  logic [DATA_WIDTH-1:0] cache_data_out,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [15:0]           hit_cnt,
   output logic [15:0]           miss_cnt
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_HIT_WAIT,
      S_MEM_RD,
      S_MEM_WR,
      S_FILL,
      S_RESP
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  wr_q;
   logic                  hit_q;
   logic [TW-1:0]         tcnt;

   // The latched request drives both the cache and memory address buses.
   assign cache_addr = addr_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         addr_q         <= '0;
         wdata_q        <= '0;
         wr_q           <= 1'b0;
         hit_q          <= 1'b0;
         tcnt           <= '0;
         cpu_req_ready  <= 1'b0;
         cpu_resp_valid <= 1'b0;
         cpu_rdata      <= '0;
         cpu_err        <= 1'b0;
         cache_data_in  <= '0;
         cache_wr_en    <= 1'b0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         hit_cnt        <= '0;
         miss_cnt       <= '0;
      end else begin
         cpu_resp_valid <= 1'b0;
         cache_wr_en    <= 1'b0;
         case (state)
            S_IDLE: begin
               cpu_req_ready <= 1'b1;
               if (cpu_req_ready && cpu_req_valid) begin
                  addr_q        <= cpu_addr;
                  wdata_q       <= cpu_wdata;
                  wr_q          <= cpu_wr_en;
                  cpu_req_ready <= 1'b0;
                  state         <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (wr_q) begin
                  hit_q   <= cache_hit;
                  mem_req <= 1'b1;
                  mem_we  <= 1'b1;
                  tcnt    <= '0;
                  state   <= S_MEM_WR;
               end else if (cache_hit) begin
                  if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                  state <= S_HIT_WAIT;
               end else begin
                  if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                  mem_req <= 1'b1;
                  mem_we  <= 1'b0;
                  tcnt    <= '0;
                  state   <= S_MEM_RD;
               end
            end
            S_HIT_WAIT: begin
               cpu_rdata      <= cache_data_out;
               cpu_err        <= 1'b0;
               cpu_resp_valid <= 1'b1;
               state          <= S_RESP;
            end
            S_MEM_RD, S_MEM_WR: begin
               // An ack arriving in the final allowed cycle still completes normally.
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  cpu_err <= 1'b0;
                  if (state == S_MEM_RD) begin
                     cpu_rdata     <= mem_rdata;
                     cache_data_in <= mem_rdata;
                     cache_wr_en   <= 1'b1;
                     state         <= S_FILL;
                  end else if (hit_q) begin
                     cache_data_in <= wdata_q;
                     cache_wr_en   <= 1'b1;
                     state         <= S_FILL;
                  end else begin
                     cpu_resp_valid <= 1'b1;
                     state          <= S_RESP;
                  end
               end else if (tcnt == TO_LAST) begin
                  mem_req        <= 1'b0;
                  mem_we         <= 1'b0;
                  cpu_err        <= 1'b1;
                  cpu_rdata      <= '0;
                  cpu_resp_valid <= 1'b1;
                  state          <= S_RESP;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            S_FILL: begin
               cpu_resp_valid <= 1'b1;
               state          <= S_RESP;
            end
            S_RESP: begin
               cpu_req_ready <= 1'b1;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - self-checking bench for cache_miss_ctrl against a transaction-level model
module tb_cache_miss_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req_valid = 1'b0;
   logic        cpu_req_ready;
   logic [31:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_wr_en = 1'b0;
   logic        cpu_resp_valid;
   logic [7:0]  cpu_rdata;
   logic        cpu_err;
   logic [31:0] cache_addr;
   logic [7:0]  cache_data_in;
   logic        cache_wr_en;
   logic        cache_hit = 1'b0;
   logic [7:0]  cache_data_out = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_rdata = '0;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int total = 0;
   int bad   = 0;
   int hit_m = 0;
   int miss_m = 0;

   typedef struct packed {
      logic [15:0] lat;
      logic [7:0]  rdata;
      logic        err;
      logic [15:0] req_cycles;
      logic [3:0]  fills;
      logic [7:0]  fill_data;
      logic        proto;
   } obs_t;

   cache_miss_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr_en(cpu_wr_en),
      .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .cache_addr(cache_addr), .cache_data_in(cache_data_in), .cache_wr_en(cache_wr_en),
      .cache_hit(cache_hit), .cache_data_out(cache_data_out),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   // Expected outcome of one request, derived from the transaction rules (latency = phase lengths).
   task automatic ref_model(input logic w, input logic h, input logic [7:0] cdo, input int ack_n,
                            input logic [7:0] md, input logic [7:0] wd, output obs_t e);
      bit to;
      int m;
      bit fill;
      e = '0;
      if (!w && h) begin
         e.lat   = 16'd3;
         e.rdata = cdo;
         if (hit_m < 65535) hit_m++;
         return;
      end
      if (!w && miss_m < 65535) miss_m++;
      to   = !(ack_n >= 1 && ack_n <= TO);
      m    = to ? TO : ack_n;
      fill = !to && (!w || h);
      e.req_cycles = 16'(m);
      e.err        = to;
      e.fills      = fill ? 4'd1 : 4'd0;
      e.fill_data  = fill ? (w ? wd : md) : 8'h00;
      e.lat        = 16'(2 + m + (fill ? 1 : 0));
      e.rdata      = (!w && !to) ? md : 8'h00;
   endtask

   // Issues one request, plays memory, and records what the DUT did.
   task automatic do_req(input logic [31:0] a, input logic [7:0] wd, input logic w, input logic h,
                         input logic [7:0] cdo, input int ack_n, input logic [7:0] md, output obs_t o);
      int reqn;
      int guard;
      bit done;
      o = '0;
      reqn = 0;
      guard = 0;
      done = 1'b0;
      @(negedge clk);
      while (!cpu_req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      cpu_req_valid = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_wr_en = w;
      cache_hit = h; cache_data_out = cdo; mem_ack = 1'b0; mem_rdata = md;
      for (int k = 1; k <= TO + 10 && !done; k++) begin
         @(negedge clk);
         cpu_req_valid = 1'b0;
         cpu_addr = $urandom;
         cpu_wdata = 8'($urandom);
         if (cpu_req_ready) o.proto = 1'b1;
         if (cache_addr !== a) o.proto = 1'b1;
         if (mem_req) begin
            reqn++;
            o.req_cycles++;
            if (mem_addr !== a || mem_we !== w || (w && mem_wdata !== wd)) o.proto = 1'b1;
         end else if (mem_we) begin
            o.proto = 1'b1;
         end
         mem_ack = mem_req && (reqn == ack_n);
         if (cache_wr_en) begin
            o.fills++;
            o.fill_data = cache_data_in;
         end
         if (cpu_resp_valid) begin
            o.lat = 16'(k);
            o.err = cpu_err;
            if (!w || cpu_err) o.rdata = cpu_rdata;
            done = 1'b1;
         end
      end
      mem_ack = 1'b0;
      @(negedge clk);
      if (cpu_resp_valid || !cpu_req_ready) o.proto = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (cpu_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", cpu_req_ready); end
      total++;
      if ({cpu_resp_valid, cpu_err, cache_wr_en, mem_req, mem_we} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=00000", {cpu_resp_valid, cpu_err, cache_wr_en, mem_req, mem_we});
      end
      total++;
      if ({hit_cnt, miss_cnt, cpu_rdata} !== 40'h0) begin
         bad++; $display("FAIL reset_regs got=%h exp=0", {hit_cnt, miss_cnt, cpu_rdata});
      end
      total++;
      if ({cache_addr, mem_addr, cache_data_in, mem_wdata} !== 80'h0) begin
         bad++; $display("FAIL reset_bus got=%h exp=0", {cache_addr, mem_addr, cache_data_in, mem_wdata});
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", cpu_req_ready); end
      hit_m = 0; miss_m = 0;
   endtask

   task automatic test_read_hit();
      obs_t o, e;
      do_req(32'h10, 8'h00, 1'b0, 1'b1, 8'h5A, 0, 8'h00, o);
      ref_model(1'b0, 1'b1, 8'h5A, 0, 8'h00, 8'h00, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL read_hit got=%h exp=%h", o, e); end
      total++;
      if (hit_cnt !== 16'(hit_m)) begin bad++; $display("FAIL read_hit_cnt got=%0d exp=%0d", hit_cnt, hit_m); end
   endtask

   task automatic test_read_miss();
      obs_t o, e;
      do_req(32'h20, 8'h00, 1'b0, 1'b0, 8'h11, 3, 8'hC3, o);
      ref_model(1'b0, 1'b0, 8'h11, 3, 8'hC3, 8'h00, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL read_miss got=%h exp=%h", o, e); end
      total++;
      if (miss_cnt !== 16'(miss_m)) begin bad++; $display("FAIL read_miss_cnt got=%0d exp=%0d", miss_cnt, miss_m); end
   endtask

   task automatic test_write();
      obs_t o, e;
      do_req(32'h30, 8'h77, 1'b1, 1'b1, 8'h00, 2, 8'hEE, o);
      ref_model(1'b1, 1'b1, 8'h00, 2, 8'hEE, 8'h77, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL write_hit got=%h exp=%h", o, e); end
      do_req(32'h31, 8'h77, 1'b1, 1'b0, 8'h00, 1, 8'hEE, o);
      ref_model(1'b1, 1'b0, 8'h00, 1, 8'hEE, 8'h77, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL write_miss got=%h exp=%h", o, e); end
      total++;
      if ({hit_cnt, miss_cnt} !== {16'(hit_m), 16'(miss_m)}) begin
         bad++; $display("FAIL write_cnts got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, hit_m, miss_m);
      end
   endtask

   task automatic test_timeout();
      obs_t o, e;
      do_req(32'h40, 8'h00, 1'b0, 1'b0, 8'h00, 0, 8'h99, o);
      ref_model(1'b0, 1'b0, 8'h00, 0, 8'h99, 8'h00, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL timeout got=%h exp=%h", o, e); end
      do_req(32'h44, 8'h00, 1'b0, 1'b0, 8'h00, TO, 8'h3C, o);
      ref_model(1'b0, 1'b0, 8'h00, TO, 8'h3C, 8'h00, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL ack_last_cycle got=%h exp=%h", o, e); end
      do_req(32'h48, 8'h55, 1'b1, 1'b1, 8'h00, 0, 8'h00, o);
      ref_model(1'b1, 1'b1, 8'h00, 0, 8'h00, 8'h55, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL write_timeout got=%h exp=%h", o, e); end
   endtask

   task automatic test_random();
      obs_t o, e;
      logic [31:0] a;
      logic [7:0] wd, cdo, md;
      logic w, h;
      int ack_n;
      for (int i = 0; i < 40; i++) begin
         a = $urandom; wd = 8'($urandom); cdo = 8'($urandom); md = 8'($urandom);
         w = 1'($urandom); h = 1'($urandom);
         ack_n = $urandom_range(0, TO + 1);
         do_req(a, wd, w, h, cdo, ack_n, md, o);
         ref_model(w, h, cdo, ack_n, md, wd, e);
         total++;
         if (o !== e) begin bad++; $display("FAIL random[%0d] w=%b h=%b ack=%0d got=%h exp=%h", i, w, h, ack_n, o, e); end
      end
      total++;
      if ({hit_cnt, miss_cnt} !== {16'(hit_m), 16'(miss_m)}) begin
         bad++; $display("FAIL random_cnts got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, hit_m, miss_m);
      end
   endtask

   task automatic test_back_to_back();
      int acc, resps, rdy_cycles, last, gap_bad, data_bad;
      acc = 0; resps = 0; rdy_cycles = 0; last = -1; gap_bad = 0; data_bad = 0;
      @(negedge clk);
      cpu_req_valid = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 32'h80;
      cache_hit = 1'b1; cache_data_out = 8'hA5; mem_ack = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (acc == 3) cpu_req_valid = 1'b0;
         if (cpu_req_valid && cpu_req_ready) acc++;
         if (cpu_req_valid && cpu_req_ready) rdy_cycles++;
         else if (cpu_req_valid && acc > 0 && acc < 3 && cpu_req_ready) rdy_cycles++;
         if (cpu_resp_valid) begin
            resps++;
            if (cpu_rdata !== 8'hA5) data_bad++;
            if (last >= 0 && k - last != 4) gap_bad++;
            last = k;
         end
         if (mem_req) gap_bad++;
         @(negedge clk);
      end
      cpu_req_valid = 1'b0;
      if (hit_m < 65533) hit_m += 3;
      total++;
      if (resps !== 3) begin bad++; $display("FAIL b2b_resp_count got=%0d exp=3", resps); end
      total++;
      if (gap_bad !== 0) begin bad++; $display("FAIL b2b_spacing got=%0d exp=0", gap_bad); end
      total++;
      if (data_bad !== 0) begin bad++; $display("FAIL b2b_rdata got=%0d exp=0", data_bad); end
      total++;
      if (rdy_cycles !== 3) begin bad++; $display("FAIL b2b_ready_cycles got=%0d exp=3", rdy_cycles); end
      total++;
      if (hit_cnt !== 16'(hit_m)) begin bad++; $display("FAIL b2b_hit_cnt got=%0d exp=%0d", hit_cnt, hit_m); end
   endtask

   task automatic test_reset_mid();
      int guard, resps;
      guard = 0; resps = 0;
      @(negedge clk);
      while (!cpu_req_ready && guard < 20) begin @(negedge clk); guard++; end
      cpu_req_valid = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 32'hCC; cache_hit = 1'b0; mem_ack = 1'b0;
      guard = 0;
      @(negedge clk);
      cpu_req_valid = 1'b0;
      while (!mem_req && guard < 10) begin @(negedge clk); guard++; end
      total++;
      if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_reach got=%b exp=1", mem_req); end
      #2 rst = 1'b0;
      #1;
      total++;
      if ({mem_req, cache_wr_en, cpu_req_ready} !== 3'b000) begin
         bad++; $display("FAIL rst_mid_async got=%b exp=000", {mem_req, cache_wr_en, cpu_req_ready});
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (cpu_resp_valid) resps++;
      end
      rst = 1'b1;
      @(negedge clk);
      if (cpu_resp_valid) resps++;
      total++;
      if (resps !== 0) begin bad++; $display("FAIL rst_mid_resp got=%0d exp=0", resps); end
      total++;
      if ({cpu_req_ready, hit_cnt, miss_cnt} !== {1'b1, 32'h0}) begin
         bad++; $display("FAIL rst_mid_after got=%b/%0d/%0d exp=1/0/0", cpu_req_ready, hit_cnt, miss_cnt);
      end
      hit_m = 0; miss_m = 0;
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_read_miss();
      test_write();
      test_timeout();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_read_hit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
